truth_table_checker: RTL and testbench

TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

---
 rtl/truth_table_checker_pkg.sv | 13 +
 rtl/truth_table_checker_hold_timer.sv | 27 ++
 rtl/truth_table_checker.sv | 110 +++++++++++
 tb/tb_truth_table_checker.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_checker_pkg.sv
// Shared types and sizing for the truth-table checker: sweep FSM states and vector geometry.
package truth_table_checker_pkg;

    localparam int NUM_VECTORS = 8;
    localparam int VEC_W       = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/truth_table_checker_hold_timer.sv
// Hold-time counter for one input vector: counts 0..HOLD_CYCLES-1 while enabled and
// pulses tc on the last count, then wraps; clear forces the count back to zero.
module ttc_hold_timer #(
    parameter int HOLD_CYCLES = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [7:0] LAST = 8'(HOLD_CYCLES - 1);

    logic [7:0] count;

    assign tc = enable && (count == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= tc ? 8'd0 : count + 8'd1;
        end
    end

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps A/B/C through all 8 vectors, holds each HOLD_CYCLES cycles and captures Y on the last.
// Optional first-failure report is built when TTC_FIRST_FAIL_EN is defined.
module truth_table_checker
    import truth_table_checker_pkg::*;
#(
    parameter int HOLD_CYCLES = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       c_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] observed
`ifdef TTC_FIRST_FAIL_EN
    ,
    output logic       fail_valid,
    output logic [2:0] first_fail_idx
`endif
);

    state_t                 state;
    state_t                 state_next;
    logic [VEC_W-1:0]       index;
    logic [NUM_VECTORS-1:0] exp_q;
    logic                   sample;
    logic                   accept_start;
    logic                   last_vec;

    // start is only honoured between sweeps; a pulse during DRIVE is dropped.
    assign accept_start = start && (state == IDLE || state == DONE);
    assign last_vec     = (index == VEC_W'(NUM_VECTORS - 1));

    ttc_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state != DRIVE),
        .enable (state == DRIVE),
        .tc     (sample)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = DRIVE;
            DRIVE:      if (sample && last_vec) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        busy                    = 1'b0;
        done                    = 1'b0;
        {a_out, b_out, c_out}   = '0;
        case (state)
            DRIVE: begin
                busy                  = 1'b1;
                {a_out, b_out, c_out} = index;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
        pass = (state == DONE) && (observed == exp_q);
    end

    // Capture path; index parks on the last vector rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_q    <= '0;
            index    <= '0;
            observed <= '0;
        end else if (accept_start) begin
            exp_q    <= expected;
            index    <= '0;
            observed <= '0;
        end else if (sample) begin
            observed[index] <= y_in;
            if (!last_vec) index <= index + 3'd1;
        end
    end

`ifdef TTC_FIRST_FAIL_EN
    // Vectors are sampled in ascending order, so the first mismatch seen is the lowest index.
    always_ff @(posedge clk) begin
        if (!rst_n || accept_start) begin
            fail_valid     <= 1'b0;
            first_fail_idx <= 3'd0;
        end else if (sample && !fail_valid && (y_in != exp_q[index])) begin
            fail_valid     <= 1'b1;
            first_fail_idx <= index;
        end
    end
`endif

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: two instances (HOLD_CYCLES 20 and 1) driving a modelled logic DUT,
// checked every cycle against a cycle-count reference model plus literal expectations.
module tb_truth_table_checker;

    localparam int H0 = 20;
    localparam int H1 = 1;

    typedef struct {
        bit         swp;
        bit         dn;
        int         k;
        logic [7:0] ex;
        logic [7:0] obs;
        bit         fv;
        logic [2:0] fi;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst_n, start;
    logic [7:0] exp0, exp1;
    logic       a0, b0, c0, busy0, done0, pass0, y0;
    logic       a1, b1, c1, busy1, done1, pass1, y1;
    logic [7:0] obs0, obs1;
`ifdef TTC_FIRST_FAIL_EN
    logic       fv0, fv1;
    logic [2:0] fi0, fi1;
`endif
    int         mode0, mode1;
    logic [7:0] tbl0, tbl1;
    int         total = 0;
    int         bad = 0;
    bit         chk_en = 1'b0;
    mdl_t       m0, m1;

    always #5 clk = ~clk;

    // Modes: 0 = A&B&C, 1 = A|B|C, 2 = ~A, other = arbitrary table.
    function automatic logic dut_y(input int md, input logic [2:0] v, input logic [7:0] t);
        case (md)
            0:       return &v;
            1:       return |v;
            2:       return ~v[2];
            default: return t[v];
        endcase
    endfunction

    assign y0 = dut_y(mode0, {a0, b0, c0}, tbl0);
    assign y1 = dut_y(mode1, {a1, b1, c1}, tbl1);

    truth_table_checker #(.HOLD_CYCLES(H0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(exp0), .y_in(y0),
        .a_out(a0), .b_out(b0), .c_out(c0), .busy(busy0), .done(done0), .pass(pass0),
        .observed(obs0)
`ifdef TTC_FIRST_FAIL_EN
        , .fail_valid(fv0), .first_fail_idx(fi0)
`endif
    );

    truth_table_checker #(.HOLD_CYCLES(H1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(exp1), .y_in(y1),
        .a_out(a1), .b_out(b1), .c_out(c1), .busy(busy1), .done(done1), .pass(pass1),
        .observed(obs1)
`ifdef TTC_FIRST_FAIL_EN
        , .fail_valid(fv1), .first_fail_idx(fi1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Model state k counts cycles since the sweep began (1..8*h); vector = (k-1)/h, sample when k%h==0.
    function automatic mdl_t step(input mdl_t m, input logic r, input logic s, input logic [7:0] e,
                                  input int h, input int md, input logic [7:0] t);
        int   v;
        logic y;
        if (!r) begin
            m = '{default: 0};
        end else if (m.swp) begin
            v = (m.k - 1) / h;
            if (m.k % h == 0) begin
                y = dut_y(md, 3'(v), t);
                m.obs[v] = y;
                if (y !== m.ex[v] && !m.fv) begin
                    m.fv = 1'b1;
                    m.fi = 3'(v);
                end
            end
            if (m.k == 8 * h) begin
                m.swp = 1'b0;
                m.dn  = 1'b1;
            end else begin
                m.k++;
            end
        end else if (s) begin
            m = '{swp: 1'b1, dn: 1'b0, k: 1, ex: e, obs: 8'h00, fv: 1'b0, fi: 3'd0};
        end
        return m;
    endfunction

    task automatic cmp_inst(input string tag, input mdl_t m, input int h, input logic [2:0] v,
                            input logic bz, input logic dn, input logic ps, input logic [7:0] ob);
        chk({tag, "_vec"},  32'(v),  m.swp ? 32'((m.k - 1) / h) : 32'd0);
        chk({tag, "_busy"}, 32'(bz), 32'(m.swp));
        chk({tag, "_done"}, 32'(dn), 32'(m.dn));
        chk({tag, "_pass"}, 32'(ps), 32'(m.dn && (m.obs == m.ex)));
        chk({tag, "_obs"},  32'(ob), 32'(m.obs));
    endtask

    // Compare at negedge, then advance the model with the inputs the next posedge will sample.
    initial begin
        m0 = '{default: 0};
        m1 = '{default: 0};
        forever begin
            @(negedge clk);
            if (chk_en) begin
                cmp_inst("i0", m0, H0, {a0, b0, c0}, busy0, done0, pass0, obs0);
                cmp_inst("i1", m1, H1, {a1, b1, c1}, busy1, done1, pass1, obs1);
`ifdef TTC_FIRST_FAIL_EN
                chk("i0_fv", 32'(fv0), 32'(m0.fv));
                chk("i0_fi", 32'(fi0), 32'(m0.fi));
                chk("i1_fv", 32'(fv1), 32'(m1.fv));
                chk("i1_fi", 32'(fi1), 32'(m1.fi));
`endif
            end
            m0 = step(m0, rst_n, start, exp0, H0, mode0, tbl0);
            m1 = step(m1, rst_n, start, exp1, H1, mode1, tbl1);
        end
    end

    // Leaves the bench #1 into cycle 1, the first DRIVE cycle.
    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Counts cycles from 1 until dut0 reports done; optionally pulses start mid-sweep.
    task automatic wait_done(input int pulse_at, input logic [7:0] pulse_exp,
                             output int n0, output int n1);
        n0 = 0;
        n1 = 0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (done1 && n1 == 0) n1 = cyc;
            if (done0) begin
                n0 = cyc;
                break;
            end
            if (cyc == pulse_at) begin
                start = 1'b1;
                exp0  = pulse_exp;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("sweep_done", 32'(done0), 32'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_vec"},  32'({a0, b0, c0}), 32'd0);
        chk({tag, "_busy"}, 32'(busy0), 32'd0);
        chk({tag, "_done"}, 32'(done0), 32'd0);
        chk({tag, "_pass"}, 32'(pass0), 32'd0);
        chk({tag, "_obs"},  32'(obs0),  32'd0);
`ifdef TTC_FIRST_FAIL_EN
        chk({tag, "_fv"},   32'(fv0), 32'd0);
        chk({tag, "_fi"},   32'(fi0), 32'd0);
`endif
    endtask

    initial begin
        int         n0, n1;
        logic [7:0] tt0, tt1;
        rst_n = 1'b0; start = 1'b0; exp0 = 8'h00; exp1 = 8'h00;
        mode0 = 0; mode1 = 2; tbl0 = 8'h00; tbl1 = 8'h00;
        @(posedge clk); #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_idle("reset");
        rst_n = 1'b1;

        // AND gate / 8'h80 on HOLD 20, ~A / 8'h0F on HOLD 1.
        exp0 = 8'h80; exp1 = 8'h0F;
        pulse_start();
        wait_done(0, 8'h00, n0, n1);
        chk("and_done_cycle", 32'(n0), 32'd161);
        chk("nota_done_cycle", 32'(n1), 32'd9);
        chk("and_obs", 32'(obs0), 32'h80);
        chk("and_pass", 32'(pass0), 32'd1);
        chk("nota_obs", 32'(obs1), 32'h0F);
        chk("nota_pass", 32'(pass1), 32'd1);

        // Back-to-back restart from DONE with an OR gate.
        mode0 = 1;
        pulse_start();
        chk("b2b_done", 32'(done0), 32'd0);
        chk("b2b_pass", 32'(pass0), 32'd0);
        chk("b2b_obs", 32'(obs0), 32'h00);
        chk("b2b_busy", 32'(busy0), 32'd1);
        chk("b2b_vec", 32'({a0, b0, c0}), 32'd0);
        wait_done(0, 8'h00, n0, n1);
        chk("or_obs", 32'(obs0), 32'hFE);
        chk("or_pass", 32'(pass0), 32'd0);
`ifdef TTC_FIRST_FAIL_EN
        chk("or_fail_valid", 32'(fv0), 32'd1);
        chk("or_first_fail", 32'(fi0), 32'd1);
`endif

        // start and expected=0 at cycle 50 must not disturb the sweep.
        mode0 = 0; exp0 = 8'h80;
        pulse_start();
        wait_done(50, 8'h00, n0, n1);
        chk("ign_done_cycle", 32'(n0), 32'd161);
        chk("ign_obs", 32'(obs0), 32'h80);
        chk("ign_pass", 32'(pass0), 32'd1);

        // Reset at cycle 70, then a clean sweep.
        exp0 = 8'h80;
        pulse_start();
        repeat (69) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        chk_idle("midrst");
        repeat (3) @(posedge clk);
        #1 chk_idle("midrst_hold");
        pulse_start();
        wait_done(0, 8'h00, n0, n1);
        chk("postrst_obs", 32'(obs0), 32'h80);
        chk("postrst_pass", 32'(pass0), 32'd1);

        // Random gates, tables and stray start pulses.
        for (int s = 0; s < 8; s++) begin
            mode0 = $urandom_range(0, 3);
            mode1 = $urandom_range(0, 3);
            tbl0  = 8'($urandom_range(0, 255));
            tbl1  = 8'($urandom_range(0, 255));
            for (int v = 0; v < 8; v++) begin
                tt0[v] = dut_y(mode0, 3'(v), tbl0);
                tt1[v] = dut_y(mode1, 3'(v), tbl1);
            end
            exp0 = ($urandom_range(0, 1) == 1) ? tt0 : 8'($urandom_range(0, 255));
            exp1 = ($urandom_range(0, 1) == 1) ? tt1 : 8'($urandom_range(0, 255));
            pulse_start();
            wait_done($urandom_range(0, 150), 8'($urandom_range(0, 255)), n0, n1);
            chk("rand_obs", 32'(obs0), 32'(tt0));
        end

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
